// File: rtl/banked_single_port_ram_pkg.sv
// Shared encodings and helpers for the banked single-port RAM.
package banked_single_port_ram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Effective per-bank address width: a memory shallower than one primitive is a single bank.
  function automatic int unsigned bank_aw(input int unsigned aw, input int unsigned baw);
    return (aw < baw) ? aw : baw;
  endfunction

endpackage

// File: rtl/banked_single_port_ram_if.sv
// Request/response bus of the banked single-port RAM.
interface banked_single_port_ram_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BYTES  = 2
);
  logic                  req;
  logic                  we;
  logic [NUM_BYTES-1:0]  be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  busy;

  modport master (output req, we, be, addr, data, input out, out_valid, busy);
  modport slave  (input req, we, be, addr, data, output out, out_valid, busy);
endinterface

// File: rtl/banked_single_port_ram_bank.sv
// One primitive-depth bank with per-lane writes and a registered read port.
module ram_bank
  import banked_single_port_ram_pkg::*;
#(
  parameter int unsigned BANK_ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned BYTE_WIDTH      = 8,
  parameter int unsigned NUM_BYTES       = DATA_WIDTH / BYTE_WIDTH,
  parameter int unsigned WRITE_MODE      = WM_READ_FIRST
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_en_i,
  input  logic                       wr_i,
  input  logic [NUM_BYTES-1:0]       lane_we_i,
  input  logic [BANK_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  localparam int unsigned DEPTH = 2 ** BANK_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign old_word = mem_q[addr_i];

  // Word as it will look after this cycle's lane writes.
  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      if (lane_we_i[k]) merged_word[k*BYTE_WIDTH +: BYTE_WIDTH] = data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array storage: only enabled lanes are written, contents are not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      if (lane_we_i[k]) mem_q[addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Registered read port; read-during-write selects old, merged or held data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      if (WRITE_MODE == WM_WRITE_FIRST) begin
        rdata_q <= merged_word;
      end else if (WRITE_MODE == WM_NO_CHANGE) begin
        if (!wr_i) rdata_q <= old_word;
      end else begin
        rdata_q <= old_word;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_single_port_ram.sv
// Depth-banked single-port RAM with byte enables, clear sequencer and optional output stage.
module banked_single_port_ram
  import banked_single_port_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned BYTE_WIDTH      = 8,
  parameter int unsigned BANK_ADDR_WIDTH = 11,
  parameter int unsigned WRITE_MODE      = WM_READ_FIRST,
  parameter int unsigned OUT_REG         = 0,
  parameter int unsigned CLEAR_ON_RESET  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  banked_single_port_ram_if.slave bus
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned BANK_AW   = bank_aw(ADDR_WIDTH, BANK_ADDR_WIDTH);
  localparam int unsigned SEL_W     = (ADDR_WIDTH > BANK_AW) ? ADDR_WIDTH - BANK_AW : 1;
  localparam int unsigned NUM_BANKS = (ADDR_WIDTH > BANK_AW) ? 2 ** SEL_W : 1;
  localparam logic [BANK_AW-1:0] CLR_MAX = '1;

  state_t                state_q;
  logic [BANK_AW-1:0]    clr_addr_q;
  logic [BANK_AW-1:0]    clr_addr_d;
  logic                  clearing;
  logic                  accepted;
  logic                  hold_sel;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      sel_q;
  logic [BANK_AW-1:0]    bank_addr;
  logic [DATA_WIDTH-1:0] bank_data;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] out2_q;
  logic                  v1_q;
  logic                  v2_q;

  assign clearing   = (state_q == ST_CLEAR);
  assign accepted   = bus.req & ~clearing;
  assign hold_sel   = bus.we & (WRITE_MODE == WM_NO_CHANGE);
  assign clr_addr_d = clr_addr_q + BANK_AW'(1);
  assign bank_addr  = clearing ? clr_addr_q : bus.addr[BANK_AW-1:0];
  assign bank_data  = clearing ? '0 : bus.data;

  // Bank decode from the upper address bits.
  generate
    if (NUM_BANKS > 1) begin : g_sel
      assign sel = bus.addr[ADDR_WIDTH-1:BANK_AW];
    end else begin : g_nosel
      assign sel = '0;
    end
  endgenerate

  // Clear sequencer: zero-fill every bank in parallel, then serve requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_d;
          if (clr_addr_q == CLR_MAX) state_q <= ST_READY;
        end
        ST_READY: state_q <= ST_READY;
        default:  state_q <= ST_CLEAR;
      endcase
    end
  end

  // One bank per primitive; only the selected bank sees the access.
  generate
    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
      logic                 hit;
      logic [NUM_BYTES-1:0] lane_we;

      assign hit     = accepted & (sel == SEL_W'(b));
      assign lane_we = clearing ? '1 : ((hit & bus.we) ? bus.be : '0);

      ram_bank #(
        .BANK_ADDR_WIDTH(BANK_AW),
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_WIDTH     (BYTE_WIDTH),
        .NUM_BYTES      (NUM_BYTES),
        .WRITE_MODE     (WRITE_MODE)
      ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (hit),
        .wr_i     (bus.we),
        .lane_we_i(lane_we),
        .addr_i   (bank_addr),
        .data_i   (bank_data),
        .rdata_o  (bank_rdata[b])
      );
    end
  endgenerate

  assign rd_word = bank_rdata[sel_q];

  // Valid pipeline, bank select aligned with bank read data, optional output stage.
  // A no-change write keeps the old select so out stays on the previous result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sel_q  <= '0;
      out2_q <= '0;
    end else begin
      v1_q <= accepted;
      v2_q <= v1_q;
      if (accepted && !hold_sel) sel_q <= sel;
      if (v1_q) out2_q <= rd_word;
    end
  end

  assign bus.out       = (OUT_REG != 0) ? out2_q : rd_word;
  assign bus.out_valid = (OUT_REG != 0) ? v2_q : v1_q;
  assign bus.busy      = clearing;

endmodule

// File: doc/banked_single_port_ram.md
Name: banked_single_port_ram

Overview:
- Parametrised successor to the depth-split single-port RAM wrapper. Splits an arbitrary-depth memory into 2^(ADDR_WIDTH-BANK_ADDR_WIDTH) banks of primitive depth.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output register, a request/valid handshake and a post-reset clear sequencer.
- Sits between datapath logic and the per-bank memory primitives. Replaces the direct recursive wrapper wherever write masking, known-zero contents or pipelined reads are required.

Parameters:
- ADDR_WIDTH, 12: total word-address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- BANK_ADDR_WIDTH, 11: primitive address width. If ADDR_WIDTH <= BANK_ADDR_WIDTH, there is one bank addressed by addr directly.
- WRITE_MODE, 0: read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 1 adds one output pipeline stage.
- CLEAR_ON_RESET, 1: 1 zero-fills all locations after reset; 0 skips the clear.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: access request, sampled on posedge clk.
- we, input, 1: write when req=1; read when we=0.
- be, input, NUM_BYTES: byte write enables; lane k covers data[k*BYTE_WIDTH +: BYTE_WIDTH].
- addr, input, ADDR_WIDTH: word address.
- data, input, DATA_WIDTH: write data.
- out, output, DATA_WIDTH: read data.
- out_valid, output, 1: out carries the result of an accepted access.
- busy, output, 1: clear in progress; requests are ignored.

Behaviour:
- Reset (async assert): out=0, out_valid=0, pipeline valids cleared, bank-select registers=0.
  - CLEAR_ON_RESET=1: FSM enters CLEAR and busy=1.
  - CLEAR_ON_RESET=0: FSM enters READY and busy=0.
  - Memory arrays are not touched by reset itself.
- FSM states:
  - CLEAR: a counter clr_addr runs 0..2^BANK_ADDR_WIDTH-1. Each cycle all banks write zero at clr_addr with every byte enabled.
  - CLEAR -> READY on the cycle clr_addr is at its maximum. busy falls the next cycle.
  - Clear duration is exactly 2^BANK_ADDR_WIDTH cycles after reset deassert.
  - READY: stays in READY until reset.
- Access acceptance: accepted = req & ~busy. While busy, req is dropped silently: no write, no out_valid.
- Bank decode: bank = addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH]; bank word address = addr[BANK_ADDR_WIDTH-1:0]. Only the selected bank sees the write enable.
- Write: bits of lane k update only if be[k]=1. be=0 with we=1 is a legal no-op write that still produces out_valid.
- Read latency:
  - OUT_REG=0: out/out_valid update on the edge after acceptance (1 cycle).
  - OUT_REG=1: 2 cycles.
  - The bank select is registered alongside the access and drives the output mux, so it lines up with the bank's read data.
- Output on an accepted write:
  - READ_FIRST: out = old word.
  - WRITE_FIRST: out = merged word (new bytes where be=1, old elsewhere).
  - NO_CHANGE: out holds its previous value; out_valid still pulses.
- out holds its value when no access completes. out_valid is high only in result cycles; back-to-back accesses give continuous out_valid.
- Reset mid-operation (during CLEAR or with reads in flight): in-flight results are discarded (no out_valid) and CLEAR restarts from 0.
- Address wrap: none. Every address is in range by construction.

Decomposition:
- Shared package: WRITE_MODE encodings (WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2) and FSM state encodings (ST_CLEAR, ST_READY).
- Sub-module ram_bank: one 2^BANK_ADDR_WIDTH x DATA_WIDTH bank.
  - Inputs: per-lane write enable, addr, data.
  - Read port registered, implementing WRITE_MODE.
  - Instantiated once per bank via generate.
- The top level holds the clear FSM, bank decode, registered bank select, output mux, OUT_REG stage and valid pipeline.

Test Plan:
1. Defaults (2 banks x 2048 x 16b): release reset -> busy=1 for exactly 2048 cycles, then 0. Reads of 0x000, 0x7FF, 0x800, 0xFFF all return 0x0000.
2. Write 0xABCD to 0x801 with be=2'b11, then read 0x801 and 0x001 -> 0xABCD and 0x0000 respectively (bank isolation); out_valid 1 cycle after each req.
3. After test 2, write 0x1234 to 0x801 with be=2'b01, then read -> 0xAB34. Also a be=2'b00 write with data 0xFFFF -> read still 0xAB34.
4. WRITE_MODE sweep, writing 0x5555 over a stored 0xAAAA:
   - READ_FIRST -> write-cycle out=0xAAAA.
   - WRITE_FIRST -> 0x5555.
   - NO_CHANGE -> out unchanged from prior value; out_valid=1 in all three.
5. OUT_REG=1 with back-to-back reads of 0x000..0x003 (preloaded 1..4) -> out=1,2,3,4 on consecutive cycles starting 2 cycles after the first req. req while busy=1 -> no out_valid and no write.
6. Assert reset at clear cycle 100 and while a read is in flight -> out=0 and out_valid=0 immediately. After release, busy lasts a full 2048 cycles and the lost read never appears.
